// File: rtl/dma_cmd_arbiter.sv
`timescale 1ns/1ps
// dma_cmd_arbiter
// Shares the single debug DMA command port between NREQ command sources.
// One owner at a time is picked round-robin. The owner keeps the port from
// command issue until dma_done arrives, or until the done-watchdog gives up.
// Ack, done and error pulses are routed back to the owning requester only.
module dma_cmd_arbiter #(
  parameter int NREQ = 2,
  parameter int CMDW = 64,
  parameter int TOW  = 20
) (
  input  logic                      gclk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           i_req_valid,
  input  logic [NREQ*CMDW-1:0]      i_req_cmd,
  output logic [NREQ-1:0]           o_req_ack,
  output logic [NREQ-1:0]           o_req_done,
  output logic [NREQ-1:0]           o_req_err,
  output logic                      o_dma_cmd_valid,
  output logic [CMDW-1:0]           o_dma_cmd,
  input  logic                      i_dma_cmd_ack,
  input  logic                      i_dma_done,
  output logic [$clog2(NREQ)-1:0]   o_grant_id,
  output logic                      o_busy,
  output logic                      o_timeout_err
);

  localparam int GW = $clog2(NREQ);
  localparam logic [GW:0]     NREQ_W   = (GW+1)'(NREQ);
  localparam logic [GW-1:0]   LAST_ID  = GW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);
  // The watchdog decides one cycle before its count would reach all-ones,
  // so the owner is released after exactly 2^TOW-1 cycles of waiting.
  localparam logic [TOW-1:0]  WD_LAST  = {{(TOW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [GW-1:0]     r_rr_ptr;
  logic [GW-1:0]     r_grant_id;
  logic [CMDW-1:0]   r_dma_cmd;
  logic              r_dma_cmd_valid;
  logic [NREQ-1:0]   r_req_ack;
  logic [NREQ-1:0]   r_req_done;
  logic [NREQ-1:0]   r_req_err;
  logic              r_timeout_err;
  logic [TOW-1:0]    r_wd_cnt;

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [GW-1:0]     w_off;
  logic [GW:0]       w_sum;
  logic [GW-1:0]     w_pick;
  logic              w_found;
  logic [CMDW-1:0]   w_sel_cmd;
  logic [NREQ-1:0]   w_grant_oh;
  logic              w_wd_expire;

  logic              w_load;
  logic              w_dma_cmd_valid_next;
  logic [NREQ-1:0]   w_req_ack_next;
  logic [NREQ-1:0]   w_req_done_next;
  logic [NREQ-1:0]   w_req_err_next;
  logic [GW-1:0]     w_rr_ptr_next;
  logic              w_timeout_set;
  logic [TOW-1:0]    w_wd_cnt_next;

  // Round-robin search: rotate the requests so rr_ptr lands on bit 0, take the
  // lowest set bit, then map the offset back to a requester index modulo NREQ.
  always_comb begin
    w_dbl   = {i_req_valid, i_req_valid};
    w_rot   = NREQ'(w_dbl >> r_rr_ptr);
    w_found = |i_req_valid;
    w_off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = GW'(i);
      end
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= NREQ_W) begin
      w_sum = w_sum - NREQ_W;
    end
    w_pick = w_sum[GW-1:0];
  end

  // Select the command slice belonging to the requester about to be granted.
  always_comb begin
    w_sel_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == GW'(i)) begin
        w_sel_cmd = i_req_cmd[i*CMDW +: CMDW];
      end
    end
  end

  assign w_grant_oh  = ONE_HOT0 << r_grant_id;
  assign w_wd_expire = (r_wd_cnt == WD_LAST);

  // State register.
  always_ff @(posedge gclk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: done beats the watchdog, and ack+done together skips WAIT_DONE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_dma_cmd_ack) begin
          w_next_state = i_dma_done ? S_IDLE : S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (i_dma_done || w_wd_expire) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output logic: next values for the registered command channel, pulses,
  // round-robin pointer and watchdog.
  always_comb begin
    w_load               = 1'b0;
    w_dma_cmd_valid_next = r_dma_cmd_valid;
    w_req_ack_next       = '0;
    w_req_done_next      = '0;
    w_req_err_next       = '0;
    w_rr_ptr_next        = r_rr_ptr;
    w_timeout_set        = 1'b0;
    w_wd_cnt_next        = r_wd_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_load               = 1'b1;
          w_dma_cmd_valid_next = 1'b1;
        end
      end
      S_ISSUE: begin
        if (i_dma_cmd_ack) begin
          w_dma_cmd_valid_next = 1'b0;
          w_req_ack_next       = w_grant_oh;
          w_rr_ptr_next        = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
          w_wd_cnt_next        = '0;
          if (i_dma_done) begin
            w_req_done_next = w_grant_oh;
          end
        end
      end
      S_WAIT_DONE: begin
        w_wd_cnt_next = r_wd_cnt + 1'b1;
        if (i_dma_done) begin
          w_req_done_next = w_grant_oh;
        end else if (w_wd_expire) begin
          w_req_done_next = w_grant_oh;
          w_req_err_next  = w_grant_oh;
          w_timeout_set   = 1'b1;
        end
      end
      default: begin
        w_dma_cmd_valid_next = 1'b0;
      end
    endcase
  end

  // Datapath registers: the granted command is latched once so a requester
  // that drops its request early still gets a stable, complete transaction.
  always_ff @(posedge gclk) begin
    if (rst) begin
      r_rr_ptr        <= '0;
      r_grant_id      <= '0;
      r_dma_cmd       <= '0;
      r_dma_cmd_valid <= 1'b0;
      r_req_ack       <= '0;
      r_req_done      <= '0;
      r_req_err       <= '0;
      r_timeout_err   <= 1'b0;
      r_wd_cnt        <= '0;
    end else begin
      if (w_load) begin
        r_grant_id <= w_pick;
        r_dma_cmd  <= w_sel_cmd;
      end
      r_rr_ptr        <= w_rr_ptr_next;
      r_dma_cmd_valid <= w_dma_cmd_valid_next;
      r_req_ack       <= w_req_ack_next;
      r_req_done      <= w_req_done_next;
      r_req_err       <= w_req_err_next;
      r_timeout_err   <= r_timeout_err | w_timeout_set;
      r_wd_cnt        <= w_wd_cnt_next;
    end
  end

  assign o_req_ack       = r_req_ack;
  assign o_req_done      = r_req_done;
  assign o_req_err       = r_req_err;
  assign o_dma_cmd_valid = r_dma_cmd_valid;
  assign o_dma_cmd       = r_dma_cmd;
  assign o_grant_id      = r_grant_id;
  assign o_busy          = (r_state != S_IDLE);
  assign o_timeout_err   = r_timeout_err;

endmodule
